// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    LDR_LEN_LO,
    LDR_LEN_HI,
    LDR_DATA,
    LDR_DONE
  } loaderState_t;

  localparam int unsigned LDR_WORD_BYTES = 4;
  localparam int unsigned LDR_LEN_BITS   = 16;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word; the first byte lands in [7:0].
module instr_mem_loader_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_accept,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam int unsigned LaneBits = $clog2(LDR_WORD_BYTES);

  logic [LaneBits-1:0] r_lane;
  logic [23:0]         r_word;
  logic                w_last_lane;

  assign w_last_lane = (r_lane == LaneBits'(LDR_WORD_BYTES - 1));

  always_ff @(posedge clk_in) begin
    if (reset || i_clear) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      // The top lane is never stored: it is forwarded straight into o_word.
      case (r_lane)
        2'd0:    r_word[7:0]   <= i_byte;
        2'd1:    r_word[15:8]  <= i_byte;
        2'd2:    r_word[23:16] <= i_byte;
        default: ;
      endcase
      r_lane <= r_lane + 1'b1;
    end
  end

  assign o_word       = {i_byte, r_word};
  assign o_word_valid = i_accept && w_last_lane;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory writes and holds the
// core in reset until the last word has been written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_POW      = 6,
  parameter int unsigned INSTR_MEM_DEPTH_POW = 10
) (
  input  logic                             clk_in,
  input  logic                             reset,
  input  logic [7:0]                       byte_in,
  input  logic                             byte_valid_in,
  output logic                             byte_ready_out,
  input  logic                             start_in,
  output logic                             memWrite_ctrl_out,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]   memAddr_out,
  output logic [31:0]                      memData_out,
  output logic                             coreReset_out,
  output logic                             done_out,
  output logic                             error_out
);

  localparam int unsigned AddrWidth = 1 << ADDR_WIDTH_POW;
  localparam int unsigned MemWords  = 1 << INSTR_MEM_DEPTH_POW;

  loaderState_t            r_state;
  loaderState_t            w_state_next;
  logic [7:0]              r_len_lo;
  logic [LDR_LEN_BITS-1:0] r_remaining;
  logic [LDR_LEN_BITS-1:0] r_word_idx;
  logic                    r_mem_write;
  logic [AddrWidth-1:0]    r_mem_addr;
  logic [31:0]             r_mem_data;
  logic                    r_core_reset;
  logic                    r_done;
  logic                    r_error;

  logic                    w_accept;
  logic [LDR_LEN_BITS-1:0] w_len;
  logic                    w_overflow;
  logic [AddrWidth-1:0]    w_addr;
  logic                    w_asm_clear;
  logic                    w_asm_accept;
  logic [31:0]             w_word;
  logic                    w_word_valid;

  assign w_accept     = byte_valid_in && byte_ready_out;
  assign w_len        = {byte_in, r_len_lo};
  assign w_overflow   = 32'(r_word_idx) >= MemWords;
  assign w_addr       = AddrWidth'({r_word_idx, 2'b00});
  assign w_asm_clear  = (r_state == LDR_LEN_HI) && w_accept;
  assign w_asm_accept = (r_state == LDR_DATA) && w_accept;

  instr_mem_loader_word_assembler u_word_assembler (
    .clk_in       (clk_in),
    .reset        (reset),
    .i_clear      (w_asm_clear),
    .i_byte       (byte_in),
    .i_accept     (w_asm_accept),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= LDR_LEN_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LDR_LEN_LO: if (w_accept) w_state_next = LDR_LEN_HI;
      LDR_LEN_HI: if (w_accept) w_state_next = (w_len == '0) ? LDR_DONE : LDR_DATA;
      LDR_DATA:   if (w_word_valid && r_remaining == 16'd1) w_state_next = LDR_DONE;
      LDR_DONE:   if (start_in) w_state_next = LDR_LEN_LO;
      default:    w_state_next = LDR_LEN_LO;
    endcase
  end

  always_comb begin
    byte_ready_out = (r_state != LDR_DONE) && !reset;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_len_lo     <= '0;
      r_remaining  <= '0;
      r_word_idx   <= '0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        LDR_LEN_LO: if (w_accept) r_len_lo <= byte_in;
        LDR_LEN_HI: begin
          if (w_accept) begin
            r_remaining <= w_len;
            r_word_idx  <= '0;
            if (w_len == '0) r_done <= 1'b1;
            if (32'(w_len) > MemWords) r_error <= 1'b1;
          end
        end
        LDR_DATA: begin
          if (w_word_valid) begin
            // Words past the end of memory are consumed but never strobed.
            r_mem_write <= !w_overflow;
            r_mem_addr  <= w_addr;
            r_mem_data  <= w_word;
            r_word_idx  <= r_word_idx + 1'b1;
            if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
            if (r_remaining == 16'd1) r_done <= 1'b1;
          end
        end
        LDR_DONE: begin
          if (start_in) begin
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
          end else begin
            r_core_reset <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign memWrite_ctrl_out = r_mem_write;
  assign memAddr_out       = r_mem_addr;
  assign memData_out       = r_mem_data;
  assign coreReset_out     = r_core_reset;
  assign done_out          = r_done;
  assign error_out         = r_error;

endmodule
